// File: rtl/ap_ctrl_seq_pkg.sv
// rtl/ap_ctrl_seq_pkg.sv - shared types and default sizes for the ap_ctrl sequencer
package ap_ctrl_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam int CNT_W_DEF        = 16;
  localparam int CYC_W_DEF        = 32;
  localparam int MAX_INFLIGHT_DEF = 2;

endpackage

// File: rtl/ap_ctrl_sequencer_sat_counter.sv
// rtl/ap_ctrl_sequencer_sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/ap_ctrl_sequencer.sv
// rtl/ap_ctrl_sequencer.sv - drives an ap_ctrl_chain kernel through a counted run
module ap_ctrl_sequencer
  import ap_ctrl_seq_pkg::*;
#(
  parameter int CNT_W        = CNT_W_DEF,
  parameter int CYC_W        = CYC_W_DEF,
  parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_count,
  output logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  output logic             ap_continue,
  input  logic             sink_ready,
  output logic             busy,
  output logic             finish,
  output logic             err,
  output logic [CNT_W-1:0] started,
  output logic [CNT_W-1:0] completed,
  output logic [CYC_W-1:0] run_cycles,
  output logic [CYC_W-1:0] stall_cycles
);

  localparam logic [CNT_W-1:0] MAX_IF = CNT_W'(MAX_INFLIGHT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] started_q, started_d;
  logic [CNT_W-1:0] completed_q, completed_d;
  logic [CNT_W-1:0] inflight_d;
  logic             err_q, err_d;
  logic             ap_start_q, ap_start_d;

  logic busy_w, accept, start_fire, done_seen, done_fire, spurious;

  assign busy_w      = (state_q == RUN) || (state_q == DRAIN);
  assign cfg_ready   = (state_q == IDLE) || (state_q == FINISH);
  assign accept      = cfg_valid && cfg_ready;
  assign ap_continue = sink_ready && busy_w;
  assign start_fire  = ap_start_q && ap_ready;
  assign done_seen   = ap_done && ap_continue;
  assign done_fire   = done_seen && (completed_q < started_q);
  assign spurious    = done_seen && (completed_q == started_q);

  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    started_d   = started_q;
    completed_d = completed_q;
    err_d       = err_q;
    case (state_q)
      IDLE, FINISH: begin
        if (accept) begin
          target_d    = cfg_count;
          started_d   = '0;
          completed_d = '0;
          err_d       = 1'b0;
          state_d     = (cfg_count == '0) ? FINISH : RUN;
        end
      end
      RUN, DRAIN: begin
        started_d   = started_q + CNT_W'(start_fire);
        completed_d = completed_q + CNT_W'(done_fire);
        err_d       = err_q || spurious;
        // Completion can never outrun starts, so reaching target on completions implies all starts issued.
        if (completed_d == target_q) begin
          state_d = FINISH;
        end else if (started_d == target_q) begin
          state_d = DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase
    inflight_d = started_d - completed_d;
    ap_start_d = (state_d == RUN) && (started_d < target_d) && (inflight_d < MAX_IF);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      target_q    <= '0;
      started_q   <= '0;
      completed_q <= '0;
      err_q       <= 1'b0;
      ap_start_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      started_q   <= started_d;
      completed_q <= completed_d;
      err_q       <= err_d;
      ap_start_q  <= ap_start_d;
    end
  end

  sat_counter #(.W(CYC_W)) u_run_cnt (
    .clock (clock),
    .reset (reset),
    .clear (accept),
    .inc   (busy_w),
    .q     (run_cycles)
  );

  sat_counter #(.W(CYC_W)) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .clear (accept),
    .inc   (ap_start_q && !ap_ready),
    .q     (stall_cycles)
  );

  assign ap_start  = ap_start_q;
  assign busy      = busy_w;
  assign finish    = (state_q == FINISH);
  assign err       = err_q;
  assign started   = started_q;
  assign completed = completed_q;

endmodule

// File: tb/tb_ap_ctrl_sequencer.sv
// tb/tb_ap_ctrl_sequencer.sv - self-checking bench for ap_ctrl_sequencer
module tb_ap_ctrl_sequencer;

  localparam int CNT_W = 16;
  localparam int CYC_W = 5;
  localparam int MAXI  = 2;
  localparam int CMAX  = (1 << CYC_W) - 1;

  logic             clock = 1'b0;
  logic             reset;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_count;
  logic             ap_start;
  logic             ap_ready;
  logic             ap_done;
  logic             ap_continue;
  logic             sink_ready;
  logic             busy;
  logic             finish;
  logic             err;
  logic [CNT_W-1:0] started;
  logic [CNT_W-1:0] completed;
  logic [CYC_W-1:0] run_cycles;
  logic [CYC_W-1:0] stall_cycles;

  ap_ctrl_sequencer #(.CNT_W(CNT_W), .CYC_W(CYC_W), .MAX_INFLIGHT(MAXI)) dut (
    .clock        (clock),
    .reset        (reset),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_count    (cfg_count),
    .ap_start     (ap_start),
    .ap_ready     (ap_ready),
    .ap_done      (ap_done),
    .ap_continue  (ap_continue),
    .sink_ready   (sink_ready),
    .busy         (busy),
    .finish       (finish),
    .err          (err),
    .started      (started),
    .completed    (completed),
    .run_cycles   (run_cycles),
    .stall_cycles (stall_cycles)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a run is either active, finished, or neither.
  bit m_active, m_fin, m_err;
  int m_target, m_started, m_completed, m_run, m_stall;

  typedef struct {
    int cnt;
    int stall_first;
    int exp_stall;
    int exp_run;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_fin = 0; m_err = 0;
    m_target = 0; m_started = 0; m_completed = 0; m_run = 0; m_stall = 0;
  endtask

  function automatic bit exp_start();
    return m_active && (m_started < m_target) && ((m_started - m_completed) < MAXI);
  endfunction

  // Called just after a falling edge; compares all outputs, advances the model, returns after next falling edge.
  task automatic step(input bit v, input int cnt, input bit rdy, input bit dn, input bit snk);
    bit es;
    cfg_valid  = v;
    cfg_count  = CNT_W'(cnt);
    ap_ready   = rdy;
    ap_done    = dn;
    sink_ready = snk;
    #1;
    es = exp_start();
    chk("cfg_ready", cfg_ready, !m_active);
    chk("busy", busy, m_active);
    chk("finish", finish, m_fin);
    chk("ap_start", ap_start, es);
    chk("ap_continue", ap_continue, m_active && snk);
    chk("err", err, m_err);
    chk("started", started, m_started);
    chk("completed", completed, m_completed);
    chk("run_cycles", run_cycles, m_run);
    chk("stall_cycles", stall_cycles, m_stall);
    if (v && !m_active) begin
      m_target = cnt; m_started = 0; m_completed = 0;
      m_run = 0; m_stall = 0; m_err = 0;
      m_active = (cnt != 0);
      m_fin = (cnt == 0);
    end else if (m_active) begin
      if (dn && snk) begin
        if (m_completed < m_started) m_completed++;
        else m_err = 1;
      end
      if (es && rdy) m_started++;
      if (es && !rdy && m_stall < CMAX) m_stall++;
      if (m_run < CMAX) m_run++;
      if (m_completed == m_target) begin
        m_active = 0;
        m_fin = 1;
      end
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  // Well-behaved kernel: first start stalled for stall_first cycles, done whenever work is outstanding.
  task automatic kernel(input int limit, input int stall_first);
    int stl;
    bit rdy;
    stl = stall_first;
    for (int c = 0; c < limit && m_active; c++) begin
      rdy = 1;
      if (exp_start() && stl > 0) begin
        rdy = 0;
        stl--;
      end
      step(0, 0, rdy, m_started > m_completed, 1);
    end
    chk("kernel_timeout", finish, 1);
  endtask

  initial begin
    vecs[0] = '{cnt: 4,  stall_first: 0, exp_stall: 0, exp_run: 5};
    vecs[1] = '{cnt: 1,  stall_first: 7, exp_stall: 7, exp_run: 9};
    vecs[2] = '{cnt: 3,  stall_first: 2, exp_stall: 2, exp_run: 6};
    vecs[3] = '{cnt: 6,  stall_first: 1, exp_stall: 1, exp_run: 8};
    vecs[4] = '{cnt: 2,  stall_first: 0, exp_stall: 0, exp_run: 3};
    vecs[5] = '{cnt: 30, stall_first: 5, exp_stall: 5, exp_run: CMAX};

    reset = 1; cfg_valid = 0; cfg_count = '0; ap_ready = 0; ap_done = 0; sink_ready = 0;
    model_reset();
    repeat (2) @(negedge clock);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_finish", finish, 0);
    chk("rst_ap_start", ap_start, 0);
    chk("rst_started", started, 0);
    chk("rst_run_cycles", run_cycles, 0);
    reset = 0;

    // ap_done in IDLE is ignored
    step(0, 0, 1, 1, 1);
    chk("idle_done_err", err, 0);

    // Table-driven runs
    foreach (vecs[i]) begin
      step(1, vecs[i].cnt, 1, 0, 1);
      kernel(200, vecs[i].stall_first);
      chk("tbl_started", started, vecs[i].cnt);
      chk("tbl_completed", completed, vecs[i].cnt);
      chk("tbl_stall", stall_cycles, vecs[i].exp_stall);
      chk("tbl_run", run_cycles, vecs[i].exp_run);
      chk("tbl_err", err, 0);
      chk("tbl_finish", finish, 1);
    end

    // Zero count then re-arm from FINISH
    step(1, 0, 1, 0, 1);
    chk("zero_finish", finish, 1);
    chk("zero_busy", busy, 0);
    step(1, 2, 1, 0, 1);
    chk("rearm_finish", finish, 0);
    chk("rearm_started", started, 0);
    chk("rearm_ap_start", ap_start, 1);
    kernel(50, 0);

    // In-flight limit
    step(1, 5, 1, 0, 1);
    repeat (10) step(0, 0, 1, 0, 1);
    chk("inflight_started", started, 2);
    chk("inflight_ap_start", ap_start, 0);
    kernel(100, 0);
    chk("inflight_completed", completed, 5);

    // Back-pressure
    step(1, 3, 1, 0, 1);
    step(0, 0, 1, 0, 1);
    for (int k = 0; k < 5; k++) begin
      cfg_valid = 0; ap_ready = 0; ap_done = 1; sink_ready = 0;
      #1 chk("bp_ap_continue", ap_continue, 0);
      step(0, 0, 0, 1, 0);
      chk("bp_completed", completed, 0);
    end
    kernel(100, 0);

    // Spurious done sets sticky err, cleared by next accept
    step(1, 2, 1, 0, 1);
    step(0, 0, 0, 1, 1);
    chk("spurious_err", err, 1);
    kernel(100, 0);
    chk("err_sticky", err, 1);
    step(1, 1, 1, 0, 1);
    chk("err_cleared", err, 0);
    kernel(50, 0);

    // Reset asserted in DRAIN
    step(1, 1, 1, 0, 1);
    step(0, 0, 1, 0, 1);
    ap_done = 0; sink_ready = 1;
    #2 reset = 1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cfg_ready", cfg_ready, 1);
    chk("mid_rst_started", started, 0);
    chk("mid_rst_ap_start", ap_start, 0);
    chk("mid_rst_ap_continue", ap_continue, 0);
    chk("mid_rst_run", run_cycles, 0);
    chk("mid_rst_finish", finish, 0);
    @(negedge clock);
    reset = 0;
    model_reset();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 6), $urandom_range(0, 9) < 7,
           $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 7);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
